// File: rtl/valve_pulse_driver.sv
// -----------------------------------------------------------------------------
// valve_pulse_driver
//
// Drives two latching-solenoid valves (A and B) from level requests issued by
// the sprinkler sequencer. Each valve has a separate open coil and close coil.
// A coil is energised for a fixed pulse and then released, so the driver keeps
// its own record of which valve it last latched open.
//
// Safety rules:
//   * Only one coil pulse runs at a time, so the two open coils are never
//     driven together.
//   * Every close pulse is followed by a dead gap.
//   * A valve is closed before the other one is opened.
//   * If flow is not confirmed after an open pulse, the driver closes the
//     valve and latches fault_noflow. While that fault is set, new opens are
//     blocked but closes still run.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset; forces a close of both valves
//   valve_A_req    level request: valve A open
//   valve_B_req    level request: valve B open
//   flow_ok        flow sensor (synchronous to clk), 1 = water flowing
//   fault_clear    single-cycle pulse clearing both sticky faults
//   coil_A_open    coil drive, valve A open coil
//   coil_A_close   coil drive, valve A close coil
//   coil_B_open    coil drive, valve B open coil
//   coil_B_close   coil drive, valve B close coil
//   busy           high whenever the driver is not idle
//   fault_noflow   sticky: no flow confirmed within FLOW_TIMEOUT after an open
//   fault_conflict sticky: both requests seen high together while idle
// -----------------------------------------------------------------------------
module valve_pulse_driver #(
    parameter int unsigned PULSE_CYCLES = 20,
    parameter int unsigned DEAD_CYCLES  = 10,
    parameter int unsigned FLOW_TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valve_A_req,
    input  logic valve_B_req,
    input  logic flow_ok,
    input  logic fault_clear,
    output logic coil_A_open,
    output logic coil_A_close,
    output logic coil_B_open,
    output logic coil_B_close,
    output logic busy,
    output logic fault_noflow,
    output logic fault_conflict
);

    typedef enum logic [2:0] {
        ST_INIT_CLOSE = 3'd0,
        ST_IDLE       = 3'd1,
        ST_PULSE_OPEN = 3'd2,
        ST_FLOW_CHECK = 3'd3,
        ST_PULSE_CLOSE= 3'd4,
        ST_DEAD       = 3'd5
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    // The counter starts at 0 when a state is entered, so a state that must
    // last N cycles ends on the edge where the counter reads N-1.
    localparam logic [15:0] PULSE_LAST = 16'(PULSE_CYCLES - 1);
    localparam logic [15:0] DEAD_LAST  = 16'(DEAD_CYCLES - 1);
    localparam logic [15:0] FLOW_LAST  = 16'(FLOW_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic        open_a_q, open_a_d;
    logic        open_b_q, open_b_d;
    logic        fault_noflow_q, fault_noflow_d;
    logic        fault_conflict_q, fault_conflict_d;

    logic eff_a, eff_b, eff_sel;
    logic pulse_done, dead_done, flow_timeout;
    logic set_noflow, set_conflict;

    // A request counts only while the other request is low. If both are
    // high, neither is honoured.
    assign eff_a   = valve_A_req & ~valve_B_req;
    assign eff_b   = valve_B_req & ~valve_A_req;
    assign eff_sel = (sel_q == SEL_B) ? eff_b : eff_a;

    assign pulse_done   = (cnt_q == PULSE_LAST);
    assign dead_done    = (cnt_q == DEAD_LAST);
    assign flow_timeout = (cnt_q == FLOW_LAST);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        open_a_d     = open_a_q;
        open_b_d     = open_b_q;
        set_noflow   = 1'b0;
        set_conflict = 1'b0;

        case (state_q)
            ST_INIT_CLOSE: begin
                if (pulse_done) begin
                    state_d = ST_DEAD;
                end
            end

            ST_DEAD: begin
                if (dead_done) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (valve_A_req && valve_B_req) begin
                    set_conflict = 1'b1;
                end
                // Closing always takes priority over opening, and A is
                // checked before B.
                if (open_a_q && !eff_a) begin
                    sel_d   = SEL_A;
                    state_d = ST_PULSE_CLOSE;
                end else if (open_b_q && !eff_b) begin
                    sel_d   = SEL_B;
                    state_d = ST_PULSE_CLOSE;
                end else if (!fault_noflow_q && !open_a_q && !open_b_q) begin
                    if (eff_a) begin
                        sel_d   = SEL_A;
                        state_d = ST_PULSE_OPEN;
                    end else if (eff_b) begin
                        sel_d   = SEL_B;
                        state_d = ST_PULSE_OPEN;
                    end
                end
            end

            ST_PULSE_OPEN: begin
                if (pulse_done) begin
                    if (sel_q == SEL_A) begin
                        open_a_d = 1'b1;
                    end else begin
                        open_b_d = 1'b1;
                    end
                    state_d = ST_FLOW_CHECK;
                end
            end

            ST_FLOW_CHECK: begin
                // Confirmed flow wins over a timeout in the same cycle.
                if (flow_ok) begin
                    state_d = ST_IDLE;
                end else if (!eff_sel) begin
                    state_d = ST_PULSE_CLOSE;
                end else if (flow_timeout) begin
                    set_noflow = 1'b1;
                    state_d    = ST_PULSE_CLOSE;
                end
            end

            ST_PULSE_CLOSE: begin
                if (pulse_done) begin
                    if (sel_q == SEL_A) begin
                        open_a_d = 1'b0;
                    end else begin
                        open_b_d = 1'b0;
                    end
                    state_d = ST_DEAD;
                end
            end

            default: begin
                state_d = ST_INIT_CLOSE;
            end
        endcase

        // A single shared counter: it restarts on every state change and
        // saturates instead of wrapping.
        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if (cnt_q == 16'hFFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        // If a fault is raised in the same cycle as fault_clear, the new
        // fault is kept.
        fault_noflow_d   = set_noflow   | (fault_noflow_q   & ~fault_clear);
        fault_conflict_d = set_conflict | (fault_conflict_q & ~fault_clear);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_INIT_CLOSE;
            cnt_q            <= 16'd0;
            sel_q            <= SEL_A;
            open_a_q         <= 1'b0;
            open_b_q         <= 1'b0;
            fault_noflow_q   <= 1'b0;
            fault_conflict_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            sel_q            <= sel_d;
            open_a_q         <= open_a_d;
            open_b_q         <= open_b_d;
            fault_noflow_q   <= fault_noflow_d;
            fault_conflict_q <= fault_conflict_d;
        end
    end

    // Coil drives depend only on the state register and sel_q. Because reset
    // forces the state register directly, the coil drives follow rst_n
    // immediately, without waiting for a clock edge.
    assign coil_A_open  = (state_q == ST_PULSE_OPEN) && (sel_q == SEL_A);
    assign coil_B_open  = (state_q == ST_PULSE_OPEN) && (sel_q == SEL_B);
    assign coil_A_close = (state_q == ST_INIT_CLOSE) ||
                          ((state_q == ST_PULSE_CLOSE) && (sel_q == SEL_A));
    assign coil_B_close = (state_q == ST_INIT_CLOSE) ||
                          ((state_q == ST_PULSE_CLOSE) && (sel_q == SEL_B));

    assign busy           = (state_q != ST_IDLE);
    assign fault_noflow   = fault_noflow_q;
    assign fault_conflict = fault_conflict_q;

endmodule

// File: tb/tb_valve_pulse_driver.sv
// -----------------------------------------------------------------------------
// tb_valve_pulse_driver
//
// Scoreboard bench for valve_pulse_driver.
//
// The reference model tracks the current phase, a count of cycles left in that
// phase, which valve is selected, and which valves are open. Each time the
// model starts a coil pulse, it queues the expected event: which coils, the
// start cycle, and the pulse length. Each time a sticky fault changes, it
// queues that change and the cycle it happens.
//
// A separate monitor watches the DUT outputs on the falling clock edge. When
// a coil pulse ends or a fault flag changes, it pops the matching queue entry
// and compares it.
//
// Inputs are driven 2 time units after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_valve_pulse_driver;

    localparam int P  = 20;
    localparam int D  = 10;
    localparam int FT = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_req = 1'b0;
    logic b_req = 1'b0;
    logic flow = 1'b0;
    logic fclr = 1'b0;
    logic coil_A_open, coil_A_close, coil_B_open, coil_B_close;
    logic busy, fault_noflow, fault_conflict;

    always #5 clk = ~clk;

    valve_pulse_driver #(
        .PULSE_CYCLES (P),
        .DEAD_CYCLES  (D),
        .FLOW_TIMEOUT (FT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valve_A_req    (a_req),
        .valve_B_req    (b_req),
        .flow_ok        (flow),
        .fault_clear    (fclr),
        .coil_A_open    (coil_A_open),
        .coil_A_close   (coil_A_close),
        .coil_B_open    (coil_B_open),
        .coil_B_close   (coil_B_close),
        .busy           (busy),
        .fault_noflow   (fault_noflow),
        .fault_conflict (fault_conflict)
    );

    // Coil masks use the order {A_open, A_close, B_open, B_close}.
    typedef struct {
        logic [3:0] mask;
        int         start;
        int         len;
    } pulse_t;

    typedef struct {
        int   which;   // 0 = noflow, 1 = conflict
        logic val;
        int   cyc;
    } fault_t;

    pulse_t pq[$];
    fault_t fq[$];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end else begin
            $display("[TB] ok %s = %0h (cycle %0d)", name, got, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_INIT = 0, M_IDLE = 1, M_OPEN = 2, M_FLOW = 3, M_CLOSE = 4, M_DEAD = 5;

    int ph      = M_INIT;
    int left    = P;
    int m_sel   = 0;
    bit m_open[2];
    bit m_nf    = 0;
    bit m_cf    = 0;
    bit m_inrst = 1;
    bit m_busy  = 1;

    task automatic start_open(input int s);
        m_sel = s;
        ph    = M_OPEN;
        left  = P;
        pq.push_back('{(s == 0) ? 4'b1000 : 4'b0010, cyc, P});
    endtask

    task automatic start_close(input int s);
        m_sel = s;
        ph    = M_CLOSE;
        left  = P;
        pq.push_back('{(s == 0) ? 4'b0100 : 4'b0001, cyc, P});
    endtask

    task automatic model_step();
        bit ea, eb, es, snf, scf, nf_n, cf_n;
        cyc++;
        if (!rst_n) begin
            ph        = M_INIT;
            left      = P;
            m_sel     = 0;
            m_open[0] = 0;
            m_open[1] = 0;
            m_nf      = 0;
            m_cf      = 0;
            m_inrst   = 1;
            m_busy    = 1;
            pq.delete();
            fq.delete();
            return;
        end
        if (m_inrst) begin
            // The cycle in which reset was released is the first cycle of
            // the power-on close pulse.
            pq.push_back('{4'b0101, cyc - 1, P});
            m_inrst = 0;
        end
        ea  = a_req && !b_req;
        eb  = b_req && !a_req;
        snf = 0;
        scf = 0;
        case (ph)
            M_INIT: begin
                left--;
                if (left == 0) begin ph = M_DEAD; left = D; end
            end
            M_DEAD: begin
                left--;
                if (left == 0) ph = M_IDLE;
            end
            M_OPEN: begin
                left--;
                if (left == 0) begin m_open[m_sel] = 1; ph = M_FLOW; left = FT; end
            end
            M_CLOSE: begin
                left--;
                if (left == 0) begin m_open[m_sel] = 0; ph = M_DEAD; left = D; end
            end
            M_IDLE: begin
                if (a_req && b_req) scf = 1;
                if (m_open[0] && !ea)      start_close(0);
                else if (m_open[1] && !eb) start_close(1);
                else if (!m_nf && !m_open[0] && !m_open[1]) begin
                    if (ea)      start_open(0);
                    else if (eb) start_open(1);
                end
            end
            M_FLOW: begin
                es = (m_sel == 1) ? eb : ea;
                if (flow)     ph = M_IDLE;
                else if (!es) start_close(m_sel);
                else begin
                    left--;
                    if (left == 0) begin snf = 1; start_close(m_sel); end
                end
            end
            default: ph = M_INIT;
        endcase
        nf_n = snf | (m_nf & !fclr);
        cf_n = scf | (m_cf & !fclr);
        if (nf_n != m_nf) fq.push_back('{0, nf_n, cyc});
        if (cf_n != m_cf) fq.push_back('{1, cf_n, cyc});
        m_nf   = nf_n;
        m_cf   = cf_n;
        m_busy = (ph != M_IDLE);
    endtask

    initial begin : model_proc
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor_proc
        logic [3:0] v, cur;
        int         st;
        bit         act;
        logic       pnf, pcf;
        pulse_t     e;
        fault_t     fe;
        act = 0;
        pnf = 0;
        pcf = 0;
        cur = 4'b0000;
        st  = 0;
        forever begin
            @(negedge clk);
            v = {coil_A_open, coil_A_close, coil_B_open, coil_B_close};
            if (!rst_n) begin
                // Any pulse that was running is abandoned.
                act = 0;
                pnf = 0;
                pcf = 0;
                chk("reset_coils", {28'd0, v}, 32'h5);
                chk("reset_busy", {31'd0, busy}, 32'd1);
                chk("reset_faults", {30'd0, fault_noflow, fault_conflict}, 32'd0);
            end else begin
                chk("coil_safety",
                    {31'd0, !(coil_A_open && coil_A_close) && !(coil_B_open && coil_B_close)
                            && !(coil_A_open && coil_B_open)}, 32'd1);
                chk("busy", {31'd0, busy}, {31'd0, m_busy});
                if (act && v != cur) begin
                    chk("pulse_expected", {31'd0, pq.size() > 0}, 32'd1);
                    if (pq.size() > 0) begin
                        e = pq.pop_front();
                        chk("pulse_coils", {28'd0, cur}, {28'd0, e.mask});
                        chk("pulse_start", st, e.start);
                        chk("pulse_len", cyc - st, e.len);
                    end
                    act = 0;
                end
                if (!act && v != 4'b0000) begin
                    act = 1;
                    cur = v;
                    st  = cyc;
                end
                if (fault_noflow !== pnf) begin
                    chk("noflow_expected", {31'd0, fq.size() > 0}, 32'd1);
                    if (fq.size() > 0) begin
                        fe = fq.pop_front();
                        chk("noflow_which", 0, fe.which);
                        chk("noflow_val", {31'd0, fault_noflow}, {31'd0, fe.val});
                        chk("noflow_cycle", cyc, fe.cyc);
                    end
                    pnf = fault_noflow;
                end
                if (fault_conflict !== pcf) begin
                    chk("conflict_expected", {31'd0, fq.size() > 0}, 32'd1);
                    if (fq.size() > 0) begin
                        fe = fq.pop_front();
                        chk("conflict_which", 1, fe.which);
                        chk("conflict_val", {31'd0, fault_conflict}, {31'd0, fe.val});
                        chk("conflict_cycle", cyc, fe.cyc);
                    end
                    pcf = fault_conflict;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : driver
        step(3);
        rst_n = 1'b1;
        // Power-on close pulse, then the dead gap, then idle.
        step(P + D + 5);

        // Open A. Flow is confirmed a few cycles after the pulse ends.
        a_req = 1'b1;
        step(1 + P + 4);
        flow = 1'b1;
        step(10);

        // Swap A for B in a single cycle: close A, dead gap, then open B.
        a_req = 1'b0;
        b_req = 1'b1;
        step(P + D + P + 10);
        b_req = 1'b0;
        flow  = 1'b0;
        step(P + D + 5);

        // No flow: timeout, fault, close. B is then held off until the fault
        // is cleared.
        a_req = 1'b1;
        step(1 + P + FT + P + D + 5);
        a_req = 1'b0;
        b_req = 1'b1;
        step(30);
        fclr = 1'b1;
        step(1);
        fclr = 1'b0;
        flow = 1'b1;
        step(P + 10);
        b_req = 1'b0;
        flow  = 1'b0;
        step(P + D + 5);

        // Conflicting requests while idle.
        a_req = 1'b1;
        b_req = 1'b1;
        step(10);
        a_req = 1'b0;
        b_req = 1'b0;
        fclr  = 1'b1;
        step(1);
        fclr = 1'b0;
        step(5);

        // Reset asserted in the middle of an open pulse.
        a_req = 1'b1;
        step(8);
        rst_n = 1'b0;
        #1;
        chk("async_abort_A_open", {31'd0, coil_A_open}, 32'd0);
        chk("async_abort_closes", {30'd0, coil_A_close, coil_B_close}, 32'd3);
        step(3);
        a_req = 1'b0;
        rst_n = 1'b1;
        step(P + D + 5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) a_req = ~a_req;
            if ($urandom_range(0, 59) == 0) b_req = ~b_req;
            flow = ($urandom_range(0, 15) == 0);
            fclr = ($urandom_range(0, 99) == 0);
            step(1);
        end

        // Drain: release everything so every expected event completes.
        a_req = 1'b0;
        b_req = 1'b0;
        flow  = 1'b0;
        fclr  = 1'b1;
        step(1);
        fclr = 1'b0;
        step(200);
        chk("pulse_queue_drained", pq.size(), 0);
        chk("fault_queue_drained", fq.size(), 0);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
